ps2_dir_decoder: RTL
====================

# ps2_dir_decoder

Converts the raw PS/2 scan-code byte stream from the keyboard controller into Pacman movement and control commands. Sits directly downstream of the PS/2 interface. It tracks make, break and extended prefixes, and holds the currently pressed direction for the game logic. It also queues edge-type commands (direction change, start, pause) in a small FIFO with a valid/ready handshake. The seven-segment debug path uses `last_code`.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `clock`  in  1: system clock.
- `resetn`  in  1: one clock; reset is asynchronous and active-low.
- `key_pressed`  in  1: byte-available flag from the PS/2 controller; pulse or level, rising-edge detected internally.
- `key_data`  in  8: scan-code byte, valid while `key_pressed` is high.
- `dir`  out  2: held direction, encoded 0 up, 1 left, 2 down, 3 right.
- `dir_valid`  out  1: a direction key is currently held.
- `cmd_valid`  out  1: FIFO head valid.
- `cmd_data`  out  3: FIFO head, encoded 0–3 direction, 4 start, 5 pause.
- `cmd_ready`  in  1: consumer accepts the head when `cmd_valid` and `cmd_ready` are both high.
- `overflow`  out  1: sticky, a command was dropped because the FIFO was full.
- `last_code`  out  8: last accepted non-prefix byte.

## Operation
- **Byte capture:** a byte is captured on a cycle where `key_pressed` is 1 and the registered `key_pressed` is 0. Only one byte is captured per rising edge.
- **Parser FSM states:** IDLE, E0, F0, E0F0.
  - IDLE: 0xE0 → E0; 0xF0 → F0; any other byte is decoded as a normal make → IDLE.
  - E0: 0xF0 → E0F0; any other byte is decoded as an extended make → IDLE.
  - F0: byte is decoded as a normal break → IDLE.
  - E0F0: byte is decoded as an extended break → IDLE.
- **Key map:**
  - Extended: 0x75 up, 0x6B left, 0x72 down, 0x74 right.
  - Normal: 0x5A start, 0x76 pause.
  - Unmapped bytes: ignored. The FSM still returns to IDLE and `last_code` still updates.
- **Direction make:**
  - Sets `dir` to the key and `dir_valid` to 1.
  - Pushes the direction command unless `dir_valid` was already 1 with the same `dir`. This suppresses typematic repeats.
- **Direction break:**
  - Clears `dir_valid` only if the key equals the current `dir`. `dir` keeps its value.
  - A break of any other key has no effect.
- **Start/pause:** each key has its own held bit. A make pushes a command only if the held bit is 0, then sets it. A break clears it.
- **FIFO:**
  - First-word fall-through: `cmd_data` is the head entry whenever `cmd_valid` is 1.
  - A push when full with no pop in the same cycle drops the new command and sets `overflow`.
  - A push and pop in the same cycle when full are both accepted, and the count is unchanged.
  - A pop when empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset values:** `dir` = 0, `dir_valid` = 0, `cmd_valid` = 0, `cmd_data` = 0, `overflow` = 0, `last_code` = 0x00. FSM state is IDLE, held bits are 0, FIFO is empty.
- **Reset mid-sequence:** prefix context is lost. A byte following reset is parsed from IDLE.

## Timing
- Capture edge at cycle N → `dir`/`dir_valid`/`last_code` updated at N+1.
- Capture at cycle N with the FIFO empty → `cmd_valid` = 1 at N+1.
- Pop at cycle N → next head, or `cmd_valid` = 0, at N+1.
- The parser accepts one byte per cycle maximum. Back-to-back rising edges every 2 cycles are handled without loss.
- All outputs are registered except `cmd_data`, which is a registered-array read at the registered read pointer.

## Configuration
- `PS2_WASD_EN`:
  - When defined, normal keys W 0x1D, A 0x1C, S 0x1B, D 0x23 also map to up/left/down/right, with identical make/break/repeat rules.
  - When undefined, these codes are unmapped and behave as ignored bytes.

## Structure
- Package `ps2_cmd_pkg` holds:
  - Command encodings: CMD_UP…CMD_PAUSE.
  - Scan-code constants: prefixes 0xE0/0xF0, the key codes above.
  - Parser state encoding.
- Sub-module `cmd_fifo`: parameterised `FIFO_DEPTH`, 3-bit data, push/pop, full/empty, first-word fall-through. The top holds the parser, held-key tracking and overflow logic.

## Test plan
- Send E0,75 → `dir` = 0, `dir_valid` = 1; one command 0 queued. Then E0,F0,75 → `dir_valid` = 0 with no new command.
- Send E0,6B three times (typematic), `cmd_ready` = 0 → exactly one command 1 in the FIFO.
- E0,75 then E0,74 held, then E0,F0,75 → `dir` = 3, `dir_valid` stays 1; queue holds 0, 3.
- Five distinct commands with `cmd_ready` = 0, depth 4 → fifth dropped, `overflow` = 1. Popping four yields 0, 1, 2, 3 in order.
- `key_pressed` held high 10 cycles with 0x5A → one start command. A second 0x5A before its F0,5A break → no second command.
- Assert `resetn` low after E0 only, release, send 0x75 → treated as a normal unmapped byte: no command, `last_code` = 0x75. With `PS2_WASD_EN`, 0x1D → command 0.

Source files
------------

// File: rtl/ps2_cmd_pkg.sv
// Shared definitions for the PS/2 direction decoder: command encodings,
// scan-code constants, parser state encoding and the key-map helper.
// Optional feature macro: PS2_WASD_EN (maps W/A/S/D normal codes to directions).
package ps2_cmd_pkg;

   localparam int unsigned CMD_W = 3;
   localparam int unsigned DIR_W = 2;
   localparam int unsigned KEY_W = 8;

   typedef enum logic [CMD_W-1:0] {
      CMD_UP    = 3'd0,
      CMD_LEFT  = 3'd1,
      CMD_DOWN  = 3'd2,
      CMD_RIGHT = 3'd3,
      CMD_START = 3'd4,
      CMD_PAUSE = 3'd5
   } cmd_e;

   localparam logic [KEY_W-1:0] SC_PREFIX_EXT = 8'hE0;
   localparam logic [KEY_W-1:0] SC_PREFIX_BRK = 8'hF0;
   localparam logic [KEY_W-1:0] SC_EXT_UP     = 8'h75;
   localparam logic [KEY_W-1:0] SC_EXT_LEFT   = 8'h6B;
   localparam logic [KEY_W-1:0] SC_EXT_DOWN   = 8'h72;
   localparam logic [KEY_W-1:0] SC_EXT_RIGHT  = 8'h74;
   localparam logic [KEY_W-1:0] SC_START      = 8'h5A;
   localparam logic [KEY_W-1:0] SC_PAUSE      = 8'h76;
`ifdef PS2_WASD_EN
   localparam logic [KEY_W-1:0] SC_W          = 8'h1D;
   localparam logic [KEY_W-1:0] SC_A          = 8'h1C;
   localparam logic [KEY_W-1:0] SC_S          = 8'h1B;
   localparam logic [KEY_W-1:0] SC_D          = 8'h23;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_E0   = 2'd1,
      ST_F0   = 2'd2,
      ST_E0F0 = 2'd3
   } parse_state_e;

   // Classification of one decoded (non-prefix) scan code.
   typedef struct packed {
      logic             is_dir;
      logic [DIR_W-1:0] dir;
      logic             is_start;
      logic             is_pause;
   } key_t;

   // Map a scan code in its extended/normal context to a game key.
   function automatic key_t decode_key(input logic ext, input logic [KEY_W-1:0] code);
      key_t k;
      k = '0;
      if (ext) begin
         case (code)
            SC_EXT_UP:    begin k.is_dir = 1'b1; k.dir = DIR_W'(CMD_UP);    end
            SC_EXT_LEFT:  begin k.is_dir = 1'b1; k.dir = DIR_W'(CMD_LEFT);  end
            SC_EXT_DOWN:  begin k.is_dir = 1'b1; k.dir = DIR_W'(CMD_DOWN);  end
            SC_EXT_RIGHT: begin k.is_dir = 1'b1; k.dir = DIR_W'(CMD_RIGHT); end
            default: ;
         endcase
      end else begin
         case (code)
            SC_START: k.is_start = 1'b1;
            SC_PAUSE: k.is_pause = 1'b1;
`ifdef PS2_WASD_EN
            SC_W: begin k.is_dir = 1'b1; k.dir = DIR_W'(CMD_UP);    end
            SC_A: begin k.is_dir = 1'b1; k.dir = DIR_W'(CMD_LEFT);  end
            SC_S: begin k.is_dir = 1'b1; k.dir = DIR_W'(CMD_DOWN);  end
            SC_D: begin k.is_dir = 1'b1; k.dir = DIR_W'(CMD_RIGHT); end
`endif
            default: ;
         endcase
      end
      return k;
   endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// Command stream between the decoder (master) and the game logic (slave).
//   cmd_valid : FIFO head valid
//   cmd_data  : FIFO head command
//   cmd_ready : consumer accepts the head when valid and ready are both high
interface ps2_dir_decoder_if;
   import ps2_cmd_pkg::*;

   logic             cmd_valid;
   logic [CMD_W-1:0] cmd_data;
   logic             cmd_ready;

   modport master (output cmd_valid, output cmd_data, input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/cmd_fifo.sv
// First-word fall-through command FIFO.
//   clk, rst_n : clock, async active-low reset
//   push_i/data_i : write request and data (dropped when full unless popped)
//   pop_i      : read request (ignored when empty)
//   full_o     : registered full flag
//   valid_o    : registered not-empty flag
//   data_o     : head entry (storage read at the registered read pointer)
module cmd_fifo #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, valid_q;
   logic              pop_ok, push_ok;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   always_comb begin
      pop_ok  = pop_i & valid_q;
      push_ok = push_i & (~full_q | pop_ok);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(FIFO_DEPTH));
         valid_q <= (count_d != '0);
      end
   end

   assign full_o  = full_q;
   assign valid_o = valid_q;
   assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 scan-code to Pacman command decoder.
//   clock, resetn : clock, async active-low reset
//   key_pressed   : byte-available flag (rising edge captures key_data)
//   key_data      : scan-code byte
//   dir/dir_valid : currently held direction
//   cmd           : command FIFO head stream (master modport)
//   overflow      : sticky, a command was dropped on a full FIFO
//   last_code     : last decoded non-prefix byte
// Optional feature macro: PS2_WASD_EN (W/A/S/D normal codes act as directions).
module ps2_dir_decoder
   import ps2_cmd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               key_pressed,
   input  logic [KEY_W-1:0]   key_data,
   output logic [DIR_W-1:0]   dir,
   output logic               dir_valid,
   output logic               overflow,
   output logic [KEY_W-1:0]   last_code,
   ps2_dir_decoder_if.master  cmd
);

   parse_state_e     state_q;
   logic             key_q;
   logic [DIR_W-1:0] dir_q;
   logic             dir_valid_q;
   logic             start_held_q, pause_held_q;
   logic             overflow_q;
   logic [KEY_W-1:0] last_code_q;

   logic             capture, decode_en, ext, brk;
   key_t             key;
   logic             push;
   logic [CMD_W-1:0] push_data;
   logic             pop, fifo_full;

   // Decode context comes from the parser state; prefixes are consumed, not decoded.
   always_comb begin
      capture   = key_pressed & ~key_q;
      decode_en = 1'b0;
      ext       = 1'b0;
      brk       = 1'b0;
      case (state_q)
         ST_IDLE: decode_en = capture & (key_data != SC_PREFIX_EXT) & (key_data != SC_PREFIX_BRK);
         ST_E0: begin
            decode_en = capture & (key_data != SC_PREFIX_BRK);
            ext       = 1'b1;
         end
         ST_F0: begin
            decode_en = capture;
            brk       = 1'b1;
         end
         ST_E0F0: begin
            decode_en = capture;
            ext       = 1'b1;
            brk       = 1'b1;
         end
         default: ;
      endcase
      key = decode_key(ext, key_data);
   end

   // Edge commands: repeats of an already-held key do not enqueue again.
   always_comb begin
      push      = 1'b0;
      push_data = '0;
      if (decode_en && !brk) begin
         if (key.is_dir && !(dir_valid_q && (dir_q == key.dir))) begin
            push      = 1'b1;
            push_data = {1'b0, key.dir};
         end else if (key.is_start && !start_held_q) begin
            push      = 1'b1;
            push_data = CMD_W'(CMD_START);
         end else if (key.is_pause && !pause_held_q) begin
            push      = 1'b1;
            push_data = CMD_W'(CMD_PAUSE);
         end
      end
      pop = cmd.cmd_valid & cmd.cmd_ready;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         key_q        <= 1'b0;
         dir_q        <= '0;
         dir_valid_q  <= 1'b0;
         start_held_q <= 1'b0;
         pause_held_q <= 1'b0;
         overflow_q   <= 1'b0;
         last_code_q  <= '0;
      end else begin
         key_q <= key_pressed;
         if (capture) begin
            case (state_q)
               ST_IDLE: begin
                  if (key_data == SC_PREFIX_EXT)      state_q <= ST_E0;
                  else if (key_data == SC_PREFIX_BRK) state_q <= ST_F0;
                  else                                state_q <= ST_IDLE;
               end
               ST_E0:   state_q <= (key_data == SC_PREFIX_BRK) ? ST_E0F0 : ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
         if (decode_en) begin
            last_code_q <= key_data;
            if (!brk) begin
               if (key.is_dir) begin
                  dir_q       <= key.dir;
                  dir_valid_q <= 1'b1;
               end
               if (key.is_start) start_held_q <= 1'b1;
               if (key.is_pause) pause_held_q <= 1'b1;
            end else begin
               // Releasing a key other than the held direction leaves it held.
               if (key.is_dir && (key.dir == dir_q)) dir_valid_q <= 1'b0;
               if (key.is_start) start_held_q <= 1'b0;
               if (key.is_pause) pause_held_q <= 1'b0;
            end
         end
         if (push && fifo_full && !pop) overflow_q <= 1'b1;
      end
   end

   cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_W     (CMD_W)
   ) u_cmd_fifo (
      .clk     (clock),
      .rst_n   (resetn),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .valid_o (cmd.cmd_valid),
      .data_o  (cmd.cmd_data)
   );

   assign dir       = dir_q;
   assign dir_valid = dir_valid_q;
   assign overflow  = overflow_q;
   assign last_code = last_code_q;

endmodule
